// File: rtl/loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | loader_pkg                                                           |
// | Shared state encodings and stream-format constants for instr_loader. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t c_st_hdr_lo = 3'd0;
  localparam state_t c_st_hdr_hi = 3'd1;
  localparam state_t c_st_load   = 3'd2;
  localparam state_t c_st_done   = 3'd3;
  localparam state_t c_st_err    = 3'd4;

  localparam int c_hdr_bytes      = 2;
  localparam int c_bytes_per_word = 4;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | byte_packer                                                          |
// | Little-endian byte-to-word shift register with a 2-bit byte index.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module byte_packer
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_full
);

  localparam int                c_idx_w    = $clog2(c_bytes_per_word);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_bytes_per_word - 1);

  logic [c_idx_w-1:0]               r_idx;
  logic [WORD_WIDTH-DATA_WIDTH-1:0] r_shift;

  // Earlier bytes sit in the low lanes, the byte on din completes the top lane.
  assign word      = {din, r_shift};
  assign word_full = shift_en && (r_idx == c_last_idx);

  always_ff @(posedge clk) begin
    if (clear) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else if (shift_en) begin
      r_idx   <= r_idx + 1'b1;
      r_shift <= word[WORD_WIDTH-1:DATA_WIDTH];
    end
  end

endmodule : byte_packer
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_loader                                                         |
// | Boot loader: byte stream -> instruction memory, then releases core.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module instr_loader
  import loader_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter int                     DATA_WIDTH    = 8,
  parameter int                     WORD_WIDTH    = 32,
  parameter int                     DEPTH_WORDS   = 256,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [WORD_WIDTH-1:0]    wr_data,
  output logic                     cpu_rst,
  output logic                     done,
  output logic                     err
);

  localparam int c_n_width = c_hdr_bytes * DATA_WIDTH;

  state_t                   r_state;
  logic [c_n_width-1:0]     r_n;
  logic [c_n_width-1:0]     r_word_cnt;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic                     r_wr_en;
  logic [ADDRESS_WIDTH-1:0] r_wr_addr;
  logic [WORD_WIDTH-1:0]    r_wr_data;

  logic                     w_accept;
  logic                     w_shift;
  logic [c_n_width-1:0]     w_n;
  logic [WORD_WIDTH-1:0]    w_word;
  logic                     w_word_full;

  assign in_ready = !rst && ((r_state == c_st_hdr_lo) ||
                             (r_state == c_st_hdr_hi) ||
                             (r_state == c_st_load));
  assign w_accept = in_valid && in_ready;
  assign w_shift  = w_accept && (r_state == c_st_load);
  assign w_n      = {in_data, r_n[DATA_WIDTH-1:0]};

  byte_packer #(
    .DATA_WIDTH(DATA_WIDTH),
    .WORD_WIDTH(WORD_WIDTH)
  ) u_packer (
    .clk      (clk),
    .clear    (rst),
    .shift_en (w_shift),
    .din      (in_data),
    .word     (w_word),
    .word_full(w_word_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_st_hdr_lo;
      r_n        <= '0;
      r_word_cnt <= '0;
      r_addr     <= BASE_ADDR;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= BASE_ADDR;
      r_wr_data  <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_accept) begin
        case (r_state)
          c_st_hdr_lo: begin
            r_n[DATA_WIDTH-1:0] <= in_data;
            r_state             <= c_st_hdr_hi;
          end
          c_st_hdr_hi: begin
            r_n <= w_n;
            if (w_n == '0)
              r_state <= c_st_done;
            else if (32'(w_n) > 32'(DEPTH_WORDS))
              r_state <= c_st_err;
            else
              r_state <= c_st_load;
          end
          c_st_load: begin
            if (w_word_full) begin
              r_wr_en    <= 1'b1;
              r_wr_addr  <= r_addr;
              r_wr_data  <= w_word;
              r_addr     <= r_addr + ADDRESS_WIDTH'(c_bytes_per_word);
              r_word_cnt <= r_word_cnt + 1'b1;
              // Leaving LOAD on the same edge as the final write releases the core with it.
              if (r_word_cnt == r_n - c_n_width'(1))
                r_state <= c_st_done;
            end
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign cpu_rst = rst || (r_state != c_st_done);
  assign done    = !rst && (r_state == c_st_done);
  assign err     = !rst && (r_state == c_st_err);

endmodule : instr_loader
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_loader                                                      |
// | Scoreboard bench: expected writes queued at drive, checked on wr_en. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int vectors    = 0;
  int miscompares = 0;
  int wr_count   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          last;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  instr_loader #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (8),
    .WORD_WIDTH   (32),
    .DEPTH_WORDS  (256),
    .BASE_ADDR    (32'h0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .cpu_rst (cpu_rst),
    .done    (done),
    .err     (err)
  );

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(posedge clk) begin
    #1;
    if (wr_en === 1'b1) begin
      wr_count++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write addr=%h data=%h", wr_addr, wr_data);
      end else begin
        e = sb.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          miscompares++;
          $display("FAIL write got %h@%h want %h@%h", wr_data, wr_addr, e.data, e.addr);
        end
        vectors++;
        if (cpu_rst !== !e.last || done !== e.last) begin
          miscompares++;
          $display("FAIL release_at_write cpu_rst=%b done=%b want cpu_rst=%b done=%b",
                   cpu_rst, done, !e.last, e.last);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    #1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout byte=%h in_ready=%b want 1", b, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_done_timeout done=%b want 1", tag, done);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, wr_en, cpu_rst, done, err} !== 5'b00100 ||
        wr_addr !== 32'h0 || wr_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_values rdy/we/crst/done/err=%b%b%b%b%b addr=%h data=%h want 00100 0 0",
               in_ready, wr_en, cpu_rst, done, err, wr_addr, wr_data);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic push_basic();
    sb.push_back('{addr: 32'h0, data: 32'h00A00513, last: 1'b0});
    sb.push_back('{addr: 32'h4, data: 32'h00100593, last: 1'b1});
  endtask

  task automatic test_basic();
    logic [7:0] img [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    int wc0;
    do_reset();
    wc0 = wr_count;
    push_basic();
    foreach (img[i]) send_byte(img[i]);
    idle();
    wait_done("basic");
    vectors++;
    if (wr_count - wc0 !== 2 || sb.size() != 0 || cpu_rst !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_end writes=%0d pending=%0d cpu_rst=%b err=%b want 2 0 0 0",
               wr_count - wc0, sb.size(), cpu_rst, err);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] img [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    int wc0;
    do_reset();
    wc0 = wr_count;
    push_basic();
    foreach (img[i]) begin
      send_byte(img[i]);
      idle();
    end
    wait_done("gaps");
    repeat (3) @(negedge clk);
    vectors++;
    if (wr_count - wc0 !== 2 || sb.size() != 0 || cpu_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL gaps_end writes=%0d pending=%0d cpu_rst=%b want 2 0 0",
               wr_count - wc0, sb.size(), cpu_rst);
    end
  endtask

  task automatic test_after_done();
    int wc0 = wr_count;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (5) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || done !== 1'b1 || cpu_rst !== 1'b0) begin
        miscompares++;
        $display("FAIL after_done rdy=%b done=%b cpu_rst=%b want 0 1 0", in_ready, done, cpu_rst);
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (wr_count !== wc0 || wr_addr !== 32'h4 || wr_data !== 32'h00100593) begin
      miscompares++;
      $display("FAIL after_done_outputs writes=%0d addr=%h data=%h want 0 4 00100593",
               wr_count - wc0, wr_addr, wr_data);
    end
  endtask

  task automatic test_zero();
    int wc0;
    do_reset();
    wc0 = wr_count;
    send_byte(8'h00);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_early_done done=%b want 0", done);
    end
    send_byte(8'h00);
    in_valid = 1'b0;
    #1;
    vectors++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || in_ready !== 1'b0 || wr_count !== wc0) begin
      miscompares++;
      $display("FAIL zero_hdr done=%b cpu_rst=%b rdy=%b writes=%0d want 1 0 0 0",
               done, cpu_rst, in_ready, wr_count - wc0);
    end
  endtask

  task automatic test_err();
    int wc0;
    do_reset();
    wc0 = wr_count;
    send_byte(8'h01);
    send_byte(8'h01);
    in_data = 8'h55;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (err !== 1'b1 || cpu_rst !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0 ||
        wr_count !== wc0) begin
      miscompares++;
      $display("FAIL err_hdr err=%b cpu_rst=%b rdy=%b done=%b writes=%0d want 1 1 0 0 0",
               err, cpu_rst, in_ready, done, wr_count - wc0);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] img [6] = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(img[i]);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, wr_en, cpu_rst, done, err} !== 5'b00100 ||
        wr_addr !== 32'h0 || wr_data !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_reset rdy/we/crst/done/err=%b%b%b%b%b addr=%h data=%h want 00100 0 0",
               in_ready, wr_en, cpu_rst, done, err, wr_addr, wr_data);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.push_back('{addr: 32'h0, data: 32'hDEADBEEF, last: 1'b1});
    foreach (img[i]) send_byte(img[i]);
    idle();
    wait_done("reload");
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL reload_pending pending=%0d want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_after_done();
    test_zero();
    test_err();
    test_mid_reset();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_instr_loader
`default_nettype wire
